// File: rtl/region_mon_pkg.sv
// Shared types and address-classification helpers for the region boundary monitor.
// Helpers take the offset width and guard size as arguments, so one copy serves any configuration.
package region_mon_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      TRACK = 1'b1
   } state_t;

   function automatic logic [31:0] region_of(input logic [31:0] a, input int off_w);
      return a >> off_w;
   endfunction

   function automatic logic is_boundary(input logic [31:0] a, input int off_w);
      logic [31:0] mask;
      mask = (32'd1 << off_w) - 32'd1;
      return (a & mask) == 32'd0;
   endfunction

   // The window sits just below the next region start; for the top region it is the wrap below 2**N.
   function automatic logic is_near(input logic [31:0] a, input int off_w, input int guard);
      logic [31:0] mask;
      mask = (32'd1 << off_w) - 32'd1;
      return (a & mask) >= ((32'd1 << off_w) - 32'(guard));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags the all-ones value.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rstN,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         sat
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   assign sat   = &count_q;
   assign count = count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && !sat) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/region_boundary_monitor.sv
// Splits the address space into 2**R_LOG2 regions and reports region, boundary/guard hits,
// region-change pulses and a saturating crossing count, all registered one cycle after sampling.
module region_boundary_monitor
   import region_mon_pkg::*;
#(
   parameter int N      = 16,
   parameter int R_LOG2 = 2,
   parameter int GUARD  = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              clear,
   input  logic              addr_valid,
   input  logic [N-1:0]      address,
   output logic              boundary_flag,
   output logic              near_boundary,
   output logic [R_LOG2-1:0] region,
   output logic              region_change,
   output logic [CNT_W-1:0]  cross_count,
   output logic              count_sat
);

   localparam int OFF_W = N - R_LOG2;

   state_t              state_q, state_d;
   logic [R_LOG2-1:0]   prev_region_q, prev_region_d;
   logic [R_LOG2-1:0]   region_q, region_d;
   logic                boundary_q, boundary_d;
   logic                near_q, near_d;
   logic                change_q, change_d;
   logic [31:0]         addr_ext;
   logic [R_LOG2-1:0]   cur_region;

   assign addr_ext   = 32'(address);
   assign cur_region = R_LOG2'(region_of(addr_ext, OFF_W));

   // A clear with a valid address behaves like the first address after reset.
   always_comb begin
      state_d       = state_q;
      prev_region_d = prev_region_q;
      region_d      = region_q;
      change_d      = 1'b0;
      boundary_d    = addr_valid && is_boundary(addr_ext, OFF_W);
      near_d        = addr_valid && is_near(addr_ext, OFF_W, GUARD);

      if (clear) begin
         if (addr_valid) begin
            prev_region_d = cur_region;
            region_d      = cur_region;
            state_d       = TRACK;
         end else begin
            state_d = IDLE;
         end
      end else if (addr_valid) begin
         if (state_q == TRACK && cur_region != prev_region_q) begin
            change_d = 1'b1;
         end
         prev_region_d = cur_region;
         region_d      = cur_region;
         state_d       = TRACK;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q       <= IDLE;
         prev_region_q <= '0;
         region_q      <= '0;
         boundary_q    <= 1'b0;
         near_q        <= 1'b0;
         change_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         prev_region_q <= prev_region_d;
         region_q      <= region_d;
         boundary_q    <= boundary_d;
         near_q        <= near_d;
         change_q      <= change_d;
      end
   end

   // Clear takes priority, so a clear cycle never counts even if tracking would have pulsed.
   sat_counter #(
      .W (CNT_W)
   ) u_cross_counter (
      .clk   (clk),
      .rstN  (rstN),
      .clr   (clear),
      .inc   (change_d),
      .count (cross_count),
      .sat   (count_sat)
   );

   assign boundary_flag = boundary_q;
   assign near_boundary = near_q;
   assign region        = region_q;
   assign region_change = change_q;

endmodule

// File: tb/tb_region_boundary_monitor.sv
// Directed bench for region_boundary_monitor at default parameters (region size 0x4000).
module tb_region_boundary_monitor;

   logic        clk;
   logic        rstN;
   logic        clear;
   logic        addr_valid;
   logic [15:0] address;
   logic        boundary_flag;
   logic        near_boundary;
   logic [1:0]  region;
   logic        region_change;
   logic [7:0]  cross_count;
   logic        count_sat;

   int total = 0;
   int bad   = 0;

   region_boundary_monitor #(
      .N      (16),
      .R_LOG2 (2),
      .GUARD  (4),
      .CNT_W  (8)
   ) dut (
      .clk           (clk),
      .rstN          (rstN),
      .clear         (clear),
      .addr_valid    (addr_valid),
      .address       (address),
      .boundary_flag (boundary_flag),
      .near_boundary (near_boundary),
      .region        (region),
      .region_change (region_change),
      .cross_count   (cross_count),
      .count_sat     (count_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are read 1 time unit after the rising edge.
   task automatic applyStimulus(input logic v, input logic [15:0] a, input logic c);
      @(negedge clk);
      addr_valid = v;
      address    = a;
      clear      = c;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic bf, input logic nb, input logic [1:0] rg,
                           input logic rc, input logic [7:0] cnt, input logic sat);
      checkOutput($sformatf("%s.boundary", tag), 32'(boundary_flag), 32'(bf));
      checkOutput($sformatf("%s.near", tag), 32'(near_boundary), 32'(nb));
      checkOutput($sformatf("%s.region", tag), 32'(region), 32'(rg));
      checkOutput($sformatf("%s.change", tag), 32'(region_change), 32'(rc));
      checkOutput($sformatf("%s.count", tag), 32'(cross_count), 32'(cnt));
      checkOutput($sformatf("%s.sat", tag), 32'(count_sat), 32'(sat));
   endtask

   initial begin
      logic [7:0] exp_cnt;
      rstN       = 1'b0;
      clear      = 1'b0;
      addr_valid = 1'b0;
      address    = 16'h0000;
      #2;
      checkAll("reset", 1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0);
      @(negedge clk);
      rstN = 1'b1;

      // Region starts in order: every sample is a boundary, crossings after the first.
      applyStimulus(1'b1, 16'h0000, 1'b0);
      checkAll("q0", 1'b1, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0);
      applyStimulus(1'b1, 16'h4000, 1'b0);
      checkAll("q1", 1'b1, 1'b0, 2'd1, 1'b1, 8'd1, 1'b0);
      applyStimulus(1'b1, 16'h8000, 1'b0);
      checkAll("q2", 1'b1, 1'b0, 2'd2, 1'b1, 8'd2, 1'b0);
      applyStimulus(1'b1, 16'hC000, 1'b0);
      checkAll("q3", 1'b1, 1'b0, 2'd3, 1'b1, 8'd3, 1'b0);

      // Guard window: move back to region 0 first, then probe its upper edge and the wrap window.
      applyStimulus(1'b1, 16'h2000, 1'b0);
      checkAll("g_pre", 1'b0, 1'b0, 2'd0, 1'b1, 8'd4, 1'b0);
      applyStimulus(1'b1, 16'h3FFB, 1'b0);
      checkAll("g_3ffb", 1'b0, 1'b0, 2'd0, 1'b0, 8'd4, 1'b0);
      applyStimulus(1'b1, 16'h3FFC, 1'b0);
      checkAll("g_3ffc", 1'b0, 1'b1, 2'd0, 1'b0, 8'd4, 1'b0);
      applyStimulus(1'b1, 16'h3FFF, 1'b0);
      checkAll("g_3fff", 1'b0, 1'b1, 2'd0, 1'b0, 8'd4, 1'b0);
      applyStimulus(1'b1, 16'hFFFC, 1'b0);
      checkAll("g_fffc", 1'b0, 1'b1, 2'd3, 1'b1, 8'd5, 1'b0);

      // Clear with a valid address at count 5: acts as a first address.
      applyStimulus(1'b1, 16'h8000, 1'b1);
      checkAll("clr_v", 1'b1, 1'b0, 2'd2, 1'b0, 8'd0, 1'b0);
      applyStimulus(1'b1, 16'h0000, 1'b0);
      checkAll("clr_next", 1'b1, 1'b0, 2'd0, 1'b1, 8'd1, 1'b0);

      // Idle gap: flags drop, region holds, no pulse on the next same-region address.
      applyStimulus(1'b1, 16'h1000, 1'b0);
      checkAll("idle_pre", 1'b0, 1'b0, 2'd0, 1'b0, 8'd1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 16'hC000, 1'b0);
         checkAll($sformatf("idle%0d", i), 1'b0, 1'b0, 2'd0, 1'b0, 8'd1, 1'b0);
      end
      applyStimulus(1'b1, 16'h1234, 1'b0);
      checkAll("idle_post", 1'b0, 1'b0, 2'd0, 1'b0, 8'd1, 1'b0);

      // Ping-pong between regions 0 and 1 until the counter saturates.
      exp_cnt = 8'd1;
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, (i % 2 == 0) ? 16'h0000 : 16'h4000, 1'b0);
         if (i != 0 && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
         checkAll($sformatf("sat%0d", i), 1'b1, 1'b0, (i % 2 == 0) ? 2'd0 : 2'd1,
                  (i != 0), exp_cnt, (exp_cnt == 8'hFF));
      end

      // Clear without a valid address: count resets, region holds, next address is a first address.
      applyStimulus(1'b0, 16'h0000, 1'b1);
      checkAll("clr_nv", 1'b0, 1'b0, 2'd1, 1'b0, 8'd0, 1'b0);
      applyStimulus(1'b1, 16'h8001, 1'b0);
      checkAll("clr_nv_next", 1'b0, 1'b0, 2'd2, 1'b0, 8'd0, 1'b0);

      // Asynchronous reset between clock edges.
      applyStimulus(1'b1, 16'hFFFE, 1'b0);
      checkAll("pre_rst", 1'b0, 1'b1, 2'd3, 1'b1, 8'd1, 1'b0);
      #2;
      rstN = 1'b0;
      #1;
      checkAll("async_rst", 1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(1'b1, 16'hC000, 1'b0);
      checkAll("post_rst", 1'b1, 1'b0, 2'd3, 1'b0, 8'd0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
